vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_if.sv | 45 ++++
 rtl/vga_timing_gen_axis.sv | 43 ++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 113 +++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Optional lookahead outputs are enabled by VGA_TIMING_PREFETCH_EN.
package vga_timing_pkg;

  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_BOTTOM  = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_TOP     = 33;

  localparam int SVGA800_H_DISPLAY = 800;
  localparam int SVGA800_H_FRONT   = 40;
  localparam int SVGA800_H_SYNC    = 128;
  localparam int SVGA800_H_BACK    = 88;
  localparam int SVGA800_V_DISPLAY = 600;
  localparam int SVGA800_V_BOTTOM  = 1;
  localparam int SVGA800_V_SYNC    = 4;
  localparam int SVGA800_V_TOP     = 23;

  typedef struct packed {
    logic [31:0] total;
    logic [31:0] sync_start;
    logic [31:0] sync_end;
  } axis_t;

  function automatic axis_t axis_calc(
    input int disp,
    input int front,
    input int sync,
    input int back
  );
    axis_t a;
    a.total      = 32'(disp + front + sync + back);
    a.sync_start = 32'(disp + front);
    a.sync_end   = 32'(disp + front + sync - 1);
    return a;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Output bundle of the VGA timing generator plus its pixel enable.
// Lookahead signals exist only with VGA_TIMING_PREFETCH_EN.
interface vga_timing_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
);
  logic               ce;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic [CNT_W-1:0]   hpos;
  logic [CNT_W-1:0]   vpos;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [CNT_W-1:0]   hpos_next;
  logic [CNT_W-1:0]   vpos_next;
  logic               display_next;
`endif

  modport master (
    input  ce,
    output hsync, vsync, display_on,
    output hpos, vpos,
    output line_start, frame_start,
    output frame_count
`ifdef VGA_TIMING_PREFETCH_EN
    , output hpos_next, vpos_next
    , output display_next
`endif
  );

  modport slave (
    output ce,
    input  hsync, vsync, display_on,
    input  hpos, vpos,
    input  line_start, frame_start,
    input  frame_count
`ifdef VGA_TIMING_PREFETCH_EN
    , input hpos_next, vpos_next
    , input display_next
`endif
  );
endinterface

// File: rtl/vga_timing_gen_axis.sv
// One timing axis: wrapping counter with registered sync window.
// Sync is computed from the next count so it aligns with count.
module vga_axis_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] disp,
  input  logic [W-1:0] sync_start,
  input  logic [W-1:0] sync_end,
  input  logic         pol,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         active,
  output logic         wrap
);
  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;

  always_comb begin
    wrap    = (count_q == limit);
    count_d = count_q;
    if (en) count_d = wrap ? '0 : count_q + W'(1);
    sync_d  = ((count_d >= sync_start) && (count_d <= sync_end))
              ? pol : ~pol;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      sync_q  <= ~pol;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count  = count_q;
  assign sync   = sync_q;
  assign active = (count_q < disp);
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: counters, syncs, strobes and frame counter.
// Define VGA_TIMING_PREFETCH_EN for one-pixel lookahead outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = VGA640_H_DISPLAY,
  parameter int H_FRONT    = VGA640_H_FRONT,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BACK     = VGA640_H_BACK,
  parameter int V_DISPLAY  = VGA640_V_DISPLAY,
  parameter int V_BOTTOM   = VGA640_V_BOTTOM,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_TOP      = VGA640_V_TOP,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input logic          clk,
  input logic          reset,
  vga_timing_if.master vif
);
  localparam axis_t H_AX =
    axis_calc(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam axis_t V_AX =
    axis_calc(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

  logic [CNT_W-1:0] h_count, v_count;
  logic             h_sync, v_sync;
  logic             h_active, v_active;
  logic             h_wrap, v_wrap;

  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  vga_axis_counter #(.W(CNT_W)) u_h (
    .clk        (clk),
    .reset      (reset),
    .en         (vif.ce),
    .limit      (CNT_W'(H_AX.total - 1)),
    .disp       (CNT_W'(H_DISPLAY)),
    .sync_start (CNT_W'(H_AX.sync_start)),
    .sync_end   (CNT_W'(H_AX.sync_end)),
    .pol        (H_SYNC_POL),
    .count      (h_count),
    .sync       (h_sync),
    .active     (h_active),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(.W(CNT_W)) u_v (
    .clk        (clk),
    .reset      (reset),
    .en         (vif.ce & h_wrap),
    .limit      (CNT_W'(V_AX.total - 1)),
    .disp       (CNT_W'(V_DISPLAY)),
    .sync_start (CNT_W'(V_AX.sync_start)),
    .sync_end   (CNT_W'(V_AX.sync_end)),
    .pol        (V_SYNC_POL),
    .count      (v_count),
    .sync       (v_sync),
    .active     (v_active),
    .wrap       (v_wrap)
  );

  always_comb begin
    line_start_d  = vif.ce & h_wrap;
    frame_start_d = line_start_d & v_wrap;
    frame_count_d = frame_count_q + FRAME_W'(frame_start_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vif.hsync       = h_sync;
  assign vif.vsync       = v_sync;
  assign vif.display_on  = h_active & v_active;
  assign vif.hpos        = h_count;
  assign vif.vpos        = v_count;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_count = frame_count_q;

`ifdef VGA_TIMING_PREFETCH_EN
  logic [CNT_W-1:0] h_nx, v_nx;

  // Pending position, shown regardless of ce
  always_comb begin
    h_nx = h_wrap ? '0 : h_count + CNT_W'(1);
    v_nx = v_count;
    if (h_wrap) v_nx = v_wrap ? '0 : v_count + CNT_W'(1);
  end

  assign vif.hpos_next    = h_nx;
  assign vif.vpos_next    = v_nx;
  assign vif.display_next = (h_nx < CNT_W'(H_DISPLAY)) &&
                            (v_nx < CNT_W'(V_DISPLAY));
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster.
// Reference derives every output from the count of ce cycles.
module tb_vga_timing_gen;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VB = 1, VS = 2, VT_ = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VB + VS + VT_;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   p = 0;
  bit   ls_e = 0, fs_e = 0;

  vga_timing_if #(.CNT_W(10), .FRAME_W(FW)) vif ();

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT_),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .CNT_W(10), .FRAME_W(FW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s p=%0d observed=%0d expected=%0d",
             tag, p, obs, exp);
    end
  endtask

  task automatic check_all();
    int h, v, f, hn, vn;
    h  = p % HT;
    v  = (p / HT) % VT;
    f  = (p / (HT * VT)) % (1 << FW);
    chk("hpos", 32'(vif.hpos), h);
    chk("vpos", 32'(vif.vpos), v);
    chk("frame_count", 32'(vif.frame_count), f);
    chk("hsync", 32'(vif.hsync),
        (h >= HD + HF && h < HD + HF + HS) ? 0 : 1);
    chk("vsync", 32'(vif.vsync),
        (v >= VD + VB && v < VD + VB + VS) ? 0 : 1);
    chk("display_on", 32'(vif.display_on), (h < HD && v < VD) ? 1 : 0);
    chk("line_start", 32'(vif.line_start), ls_e);
    chk("frame_start", 32'(vif.frame_start), fs_e);
    hn = (p + 1) % HT;
    vn = ((p + 1) / HT) % VT;
`ifdef VGA_TIMING_PREFETCH_EN
    chk("hpos_next", 32'(vif.hpos_next), hn);
    chk("vpos_next", 32'(vif.vpos_next), vn);
    chk("display_next", 32'(vif.display_next),
        (hn < HD && vn < VD) ? 1 : 0);
`else
    if (hn < 0 || vn < 0) $error("FAIL lookahead hn=%0d vn=%0d", hn, vn);
`endif
  endtask

  task automatic step(input bit r, input bit c);
    reset  = r;
    vif.ce = c;
    @(posedge clk);
    if (r) begin
      p = 0; ls_e = 0; fs_e = 0;
    end else if (c) begin
      p++;
      ls_e = (p % HT == 0);
      fs_e = (p % (HT * VT) == 0);
    end else begin
      ls_e = 0; fs_e = 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    reset  = 1'b1;
    vif.ce = 1'b1;
    // Reset held with ce high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    // Free run across five frames to see frame_count wrap
    for (int i = 0; i < 5 * HT * VT; i++) step(1'b0, 1'b1);
    // 50% ce duty
    for (int i = 0; i < 4 * HT * VT; i++) step(1'b0, i[0]);
    // Random ce
    for (int i = 0; i < 1000; i++)
      step(1'b0, $urandom_range(0, 3) != 0);
    // Mid-frame reset
    while ((p % HT) != 11 || ((p / HT) % VT) != 3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    // Random ce with occasional reset, including at wrap points
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
    for (int i = 0; i < HT * VT - 1; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
